// File: rtl/ram_sync_be_pkg.sv
// Shared types and constants for the byte-enabled synchronous RAM.
// Holds the sequencer state encoding and the legal read-latency range.
package ram_sync_be_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    function automatic bit lat_is_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_sync_be_if.sv
// Write/read request bus of ram_sync_be.
// The master issues requests; the slave (the RAM) returns read data and busy status.
interface ram_sync_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );

endinterface

// File: rtl/ram_sync_be_rd_pipe.sv
// Extra read-response delay: {valid, data} move through STAGES-1 registers.
// Data registers only load on a valid beat, so the output holds its last response.
module ram_sync_be_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    if (STAGES < 2) begin : g_pass
        assign vld_o  = vld_i;
        assign data_o = data_i;
    end else begin : g_pipe
        localparam int N = STAGES - 1;

        logic [N-1:0]     vld_q;
        logic [WIDTH-1:0] data_q [N];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int s = 0; s < N; s++) begin
                    data_q[s] <= '0;
                end
            end else begin
                vld_q[0] <= vld_i;
                if (vld_i) begin
                    data_q[0] <= data_i;
                end
                for (int s = 1; s < N; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                    end
                end
            end
        end

        assign vld_o  = vld_q[N-1];
        assign data_o = data_q[N-1];
    end

endmodule

// File: rtl/ram_sync_be.sv
// Synchronous RAM with per-byte write enables, 1- or 2-cycle reads, selectable
// read-during-write behaviour and a post-reset clear sequencer.
module ram_sync_be
    import ram_sync_be_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 5,
    parameter int                    READ_LATENCY = 1,
    parameter int                    RDW_NEW      = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sync_be_if.slave  bus
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "ram_sync_be: DATA_WIDTH must be a multiple of 8");
    end
    if (!lat_is_legal(READ_LATENCY)) begin : g_bad_latency
        $fatal(1, "ram_sync_be: READ_LATENCY must be 1 or 2");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_be(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  init_busy_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  run;
    logic                  clr_we;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] wr_word_d;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word_d;

    // Requests only take effect once the array is cleared and reset is released.
    assign run       = (state_q == ST_RUN);
    assign clr_we    = rst_n && (state_q == ST_CLEAR);
    assign wr_fire   = rst_n && run && bus.wr_en;
    assign rd_fire   = rst_n && run && bus.rd_en;
    assign wr_word_d = merge_be(mem_q[bus.wr_addr], bus.wr_data, bus.wr_be);
    assign rd_old    = mem_q[bus.rd_addr];

    if (RDW_NEW != 0) begin : g_rdw_new
        assign rd_word_d = (wr_fire && (bus.wr_addr == bus.rd_addr)) ? wr_word_d : rd_old;
    end else begin : g_rdw_old
        assign rd_word_d = rd_old;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_CLEAR;
                    cnt_q       <= '0;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else if (wr_fire) begin
            mem_q[bus.wr_addr] <= wr_word_d;
        end
    end

    // ---- read stage p0: array output registered, holds between reads ----
    logic                  rd_vld_p0_q;
    logic [DATA_WIDTH-1:0] rd_data_p0_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_p0_q  <= 1'b0;
            rd_data_p0_q <= '0;
        end else begin
            rd_vld_p0_q <= rd_fire;
            if (rd_fire) begin
                rd_data_p0_q <= rd_word_d;
            end
        end
    end

    // ---- optional stage p1 for two-cycle reads ----
    logic                  rd_vld_o;
    logic [DATA_WIDTH-1:0] rd_data_o;

    if (READ_LATENCY > 1) begin : g_lat2
        ram_sync_be_rd_pipe #(
            .WIDTH  (DATA_WIDTH),
            .STAGES (READ_LATENCY)
        ) u_rd_pipe (
            .clk    (clk),
            .rst_n  (rst_n),
            .vld_i  (rd_vld_p0_q),
            .data_i (rd_data_p0_q),
            .vld_o  (rd_vld_o),
            .data_o (rd_data_o)
        );
    end else begin : g_lat1
        assign rd_vld_o  = rd_vld_p0_q;
        assign rd_data_o = rd_data_p0_q;
    end

    assign bus.rd_data   = rd_data_o;
    assign bus.rd_valid  = rd_vld_o;
    assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_ram_sync_be.sv
// Directed bench for ram_sync_be: instance A (latency 1, old-data RDW, init 0)
// and instance B (latency 2, new-data RDW, init A5A55A5A) share one stimulus stream.
module tb_ram_sync_be;

    localparam logic [31:0] INIT_B = 32'hA5A5_5A5A;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [4:0]  ra;

    int total;
    int bad;

    ram_sync_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifa ();
    ram_sync_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifb ();

    assign ifa.wr_en   = we;
    assign ifa.wr_addr = wa;
    assign ifa.wr_data = wd;
    assign ifa.wr_be   = be;
    assign ifa.rd_en   = re;
    assign ifa.rd_addr = ra;
    assign ifb.wr_en   = we;
    assign ifb.wr_addr = wa;
    assign ifb.wr_data = wd;
    assign ifb.wr_be   = be;
    assign ifb.rd_en   = re;
    assign ifb.rd_addr = ra;

    ram_sync_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1), .RDW_NEW(0), .INIT_VALUE(32'h0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    ram_sync_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(2), .RDW_NEW(1), .INIT_VALUE(INIT_B)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [4:0]  ra;
        logic        va;
        logic [31:0] da;
        logic        vb;
        logic [31:0] db;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = '0; wd = '0; be = '0; re = 1'b0; ra = '0;
    endtask

    // Entered at the negedge where rst_n was just released (init_busy still 1 from reset).
    task automatic run_clear(input string tag);
        int k;
        int vseen;
        k = 0;
        vseen = 0;
        while (ifa.init_busy && k < 100) begin
            @(negedge clk);
            k++;
            if (ifa.rd_valid || ifb.rd_valid) vseen++;
        end
        idle_inputs();
        @(negedge clk);
        if (ifa.rd_valid || ifb.rd_valid) vseen++;
        chk({tag, "_busy_cycles"}, k, 32);
        chk({tag, "_busy_b_low"}, {31'b0, ifb.init_busy}, 32'd0);
        chk({tag, "_no_rd_valid"}, vseen, 0);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
        re = 1'b1; ra = addr;
        @(negedge clk);
        re = 1'b0;
        chk({tag, "_va"}, {31'b0, ifa.rd_valid}, 32'd1);
        chk({tag, "_da"}, ifa.rd_data, exp_a);
        @(negedge clk);
        chk({tag, "_vb"}, {31'b0, ifb.rd_valid}, 32'd1);
        chk({tag, "_db"}, ifb.rd_data, exp_b);
        chk({tag, "_va_drop"}, {31'b0, ifa.rd_valid}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Each vector: inputs applied at a negedge, outputs checked one clock later.
        vq.push_back('{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 1'b0, 32'h00000000, 1'b0, INIT_B});
        vq.push_back('{1'b1, 5'd5, 32'h0000AA00, 4'h2, 1'b0, 5'd0, 1'b0, 32'h00000000, 1'b0, INIT_B});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd5, 1'b1, 32'hDEADAAEF, 1'b0, INIT_B});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'hDEADAAEF, 1'b1, 32'hDEADAAEF});
        vq.push_back('{1'b1, 5'd1, 32'h01010101, 4'hF, 1'b0, 5'd0, 1'b0, 32'hDEADAAEF, 1'b0, 32'hDEADAAEF});
        vq.push_back('{1'b1, 5'd2, 32'h02020202, 4'hF, 1'b0, 5'd0, 1'b0, 32'hDEADAAEF, 1'b0, 32'hDEADAAEF});
        vq.push_back('{1'b1, 5'd3, 32'h03030303, 4'hF, 1'b0, 5'd0, 1'b0, 32'hDEADAAEF, 1'b0, 32'hDEADAAEF});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd1, 1'b1, 32'h01010101, 1'b0, 32'hDEADAAEF});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd2, 1'b1, 32'h02020202, 1'b1, 32'h01010101});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 1'b1, 32'h03030303, 1'b1, 32'h02020202});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h03030303, 1'b1, 32'h03030303});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h03030303, 1'b0, 32'h03030303});
        vq.push_back('{1'b1, 5'd7, 32'h11111111, 4'hF, 1'b0, 5'd0, 1'b0, 32'h03030303, 1'b0, 32'h03030303});
        vq.push_back('{1'b1, 5'd7, 32'h22222222, 4'hF, 1'b1, 5'd7, 1'b1, 32'h11111111, 1'b0, 32'h03030303});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h11111111, 1'b1, 32'h22222222});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd7, 1'b1, 32'h22222222, 1'b0, 32'h22222222});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h22222222, 1'b1, 32'h22222222});
        vq.push_back('{1'b1, 5'd7, 32'h000000FF, 4'h1, 1'b1, 5'd7, 1'b1, 32'h22222222, 1'b0, 32'h22222222});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h22222222, 1'b1, 32'h222222FF});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd7, 1'b1, 32'h222222FF, 1'b0, 32'h222222FF});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h222222FF, 1'b1, 32'h222222FF});
        vq.push_back('{1'b1, 5'd8, 32'hAAAA5555, 4'hF, 1'b1, 5'd1, 1'b1, 32'h01010101, 1'b0, 32'h222222FF});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h01010101, 1'b1, 32'h01010101});
        vq.push_back('{1'b1, 5'd1, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0, 1'b0, 32'h01010101, 1'b0, 32'h01010101});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd1, 1'b1, 32'h01010101, 1'b0, 32'h01010101});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd8, 1'b1, 32'hAAAA5555, 1'b1, 32'h01010101});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'hAAAA5555, 1'b1, 32'hAAAA5555});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'hAAAA5555, 1'b0, 32'hAAAA5555});
        vq.push_back('{1'b1, 5'd9, 32'h12345678, 4'hC, 1'b0, 5'd0, 1'b0, 32'hAAAA5555, 1'b0, 32'hAAAA5555});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd9, 1'b1, 32'h12340000, 1'b0, 32'hAAAA5555});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h12340000, 1'b1, 32'h12345A5A});
        vq.push_back('{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 32'h12340000, 1'b0, 32'h12345A5A});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy_a", {31'b0, ifa.init_busy}, 32'd1);
        chk("rst_busy_b", {31'b0, ifb.init_busy}, 32'd1);
        chk("rst_valid_a", {31'b0, ifa.rd_valid}, 32'd0);
        chk("rst_valid_b", {31'b0, ifb.rd_valid}, 32'd0);
        chk("rst_data_a", ifa.rd_data, 32'h0);
        chk("rst_data_b", ifb.rd_data, 32'h0);

        // Clear after reset, with writes/reads to addr 0 hammering the whole time
        rst_n = 1'b1;
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; be = 4'hF; re = 1'b1; ra = 5'd0;
        run_clear("clr1");

        // Full-throughput read of the whole array
        for (int c = 0; c < 34; c++) begin
            if (c < 32) begin
                re = 1'b1;
                ra = 5'(c);
            end else begin
                re = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("fill%0d_va", c), {31'b0, ifa.rd_valid}, (c < 32) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_da", c), ifa.rd_data, 32'h0);
            chk($sformatf("fill%0d_vb", c), {31'b0, ifb.rd_valid}, (c >= 1 && c <= 32) ? 32'd1 : 32'd0);
            if (c >= 1) chk($sformatf("fill%0d_db", c), ifb.rd_data, INIT_B);
        end

        // Directed vector table
        foreach (vq[i]) begin
            we = vq[i].we; wa = vq[i].wa; wd = vq[i].wd; be = vq[i].be;
            re = vq[i].re; ra = vq[i].ra;
            @(negedge clk);
            chk($sformatf("vec%0d_va", i), {31'b0, ifa.rd_valid}, {31'b0, vq[i].va});
            chk($sformatf("vec%0d_da", i), ifa.rd_data, vq[i].da);
            chk($sformatf("vec%0d_vb", i), {31'b0, ifb.rd_valid}, {31'b0, vq[i].vb});
            chk($sformatf("vec%0d_db", i), ifb.rd_data, vq[i].db);
        end
        idle_inputs();

        // Reset at cycle 10 of CLEAR restarts the sequencer; busy writes are dropped
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("midclr_busy", {31'b0, ifa.init_busy}, 32'd1);
        rst_n = 1'b0;
        we = 1'b1; wa = 5'd0; wd = 32'h77777777; be = 4'hF; re = 1'b1; ra = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_clear("clr2");
        rd_check("after_clr_a0", 5'd0, 32'h0, INIT_B);
        rd_check("after_clr_a5", 5'd5, 32'h0, INIT_B);
        rd_check("after_clr_a9", 5'd9, 32'h0, INIT_B);

        // Read in flight when reset hits is discarded
        we = 1'b1; wa = 5'd4; wd = 32'h44444444; be = 4'hF;
        @(negedge clk);
        idle_inputs();
        re = 1'b1; ra = 5'd4;
        @(negedge clk);
        re = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("flush_va", {31'b0, ifa.rd_valid}, 32'd0);
        chk("flush_vb", {31'b0, ifb.rd_valid}, 32'd0);
        chk("flush_da", ifa.rd_data, 32'h0);
        chk("flush_db", ifb.rd_data, 32'h0);
        rst_n = 1'b1;
        run_clear("clr3");
        chk("post_flush_da", ifa.rd_data, 32'h0);
        chk("post_flush_db", ifb.rd_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
